spi_slave_gen: RTL

Parametrised SPI slave front end, the successor of the fixed 10-bit slave. It deserialises a (DATA_W+2)-bit command word from MOSI and presents it to the memory as a single-cycle rx_valid pulse. For read-data commands it serialises the tx_data returned by the memory onto MISO. Compared with the fixed slave, it adds read-address sequencing checks, frame-abort detection, a tx response timeout and a busy status. It sits between the wrapper's SPI pins and the RAM controller.

---
 rtl/spi_slave_gen_if.sv | 25 ++
 rtl/spi_slave_gen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/spi_slave_gen_if.sv
// SPI pin and memory-side signal bundle for spi_slave_gen.
interface spi_slave_gen_if #(
  parameter int unsigned DATA_W = 8
);
  logic              ss_n;
  logic              mosi;
  logic              miso;
  logic              rx_valid;
  logic [DATA_W+1:0] rx_data;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              err;
  logic              abort;
  logic              busy;

  modport master (
    output ss_n, mosi, tx_valid, tx_data,
    input  miso, rx_valid, rx_data, err, abort, busy
  );

  modport slave (
    input  ss_n, mosi, tx_valid, tx_data,
    output miso, rx_valid, rx_data, err, abort, busy
  );
endinterface

// File: rtl/spi_slave_gen.sv
// Parametrised SPI slave: deserialises (DATA_W+2)-bit command frames and
// serialises memory read data, with read sequencing, abort and timeout checks.
module spi_slave_gen #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TX_TIMEOUT = 16
) (
  input logic            clk,
  input logic            rst_n,
  spi_slave_gen_if.slave bus
);
  localparam int unsigned FRAME_W = DATA_W + 2;
  localparam int unsigned BCW     = $clog2(FRAME_W + 1);
  localparam int unsigned TOW     = $clog2(TX_TIMEOUT + 1);
  localparam int unsigned TCW     = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, RECV, WAIT_TX, SEND, DONE} state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-2:0] rx_shift_q, rx_shift_d;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [TOW-1:0]     to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0]  tx_shift_q, tx_shift_d;
  logic [TCW-1:0]     tx_cnt_q, tx_cnt_d;
  logic               miso_q, miso_d;
  logic               rx_valid_q, rx_valid_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               err_q, err_d;
  logic               abort_q, abort_d;
  logic               rd_ok_q, rd_ok_d;
  logic [FRAME_W-1:0] word;

  // The top FRAME_W-1 bits live in the shift register; the last bit comes straight from mosi.
  assign word = {rx_shift_q, bus.mosi};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rx_shift_q <= '0;
      bit_cnt_q  <= '0;
      to_cnt_q   <= '0;
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      miso_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      to_cnt_q   <= to_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      miso_q     <= miso_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
      rd_ok_q    <= rd_ok_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    to_cnt_d   = to_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    miso_d     = miso_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    err_d      = 1'b0;
    abort_d    = 1'b0;
    rd_ok_d    = rd_ok_q;

    if (bus.ss_n) begin
      state_d = IDLE;
      miso_d  = 1'b0;
      abort_d = (state_q == RECV) || (state_q == WAIT_TX) || (state_q == SEND);
    end else begin
      unique case (state_q)
        IDLE: begin
          rx_shift_d = {rx_shift_q[FRAME_W-3:0], bus.mosi};
          bit_cnt_d  = BCW'(1);
          state_d    = RECV;
        end
        RECV: begin
          rx_shift_d = {rx_shift_q[FRAME_W-3:0], bus.mosi};
          bit_cnt_d  = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == BCW'(FRAME_W - 1)) begin
            state_d = DONE;
            unique case (word[FRAME_W-1:FRAME_W-2])
              2'b10: begin
                rx_data_d  = word;
                rx_valid_d = 1'b1;
                rd_ok_d    = 1'b1;
              end
              2'b11: begin
                if (rd_ok_q) begin
                  rx_data_d  = word;
                  rx_valid_d = 1'b1;
                  rd_ok_d    = 1'b0;
                  to_cnt_d   = '0;
                  state_d    = WAIT_TX;
                end else begin
                  err_d = 1'b1;
                end
              end
              default: begin
                rx_data_d  = word;
                rx_valid_d = 1'b1;
              end
            endcase
          end
        end
        WAIT_TX: begin
          if (bus.tx_valid) begin
            miso_d     = bus.tx_data[DATA_W-1];
            tx_shift_d = bus.tx_data << 1;
            tx_cnt_d   = TCW'(1);
            state_d    = SEND;
          end else begin
            to_cnt_d = to_cnt_q + TOW'(1);
            if (to_cnt_q == TOW'(TX_TIMEOUT - 1)) begin
              err_d   = 1'b1;
              state_d = DONE;
            end
          end
        end
        SEND: begin
          if (tx_cnt_q < TCW'(DATA_W)) begin
            miso_d     = tx_shift_q[DATA_W-1];
            tx_shift_d = tx_shift_q << 1;
            tx_cnt_d   = tx_cnt_q + TCW'(1);
          end else begin
            miso_d  = 1'b0;
            state_d = DONE;
          end
        end
        DONE: miso_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.miso     = miso_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.err      = err_q;
  assign bus.abort    = abort_q;
  assign bus.busy     = (state_q != IDLE);
endmodule
